difftest_instr_commit: RTL and testbench
========================================

DIFFTEST_INSTR_COMMIT -- requirements
Module: difftest_instr_commit

Interface
REQ-001 Parameter XLEN, default 32, data/PC width.
REQ-002 Parameter NREG, default 32, architectural GPR count.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 coreid  in  8  core identifier, latched into status only.
REQ-006 index  in  8  commit slot index, latched with each commit.
REQ-007 valid  in  1  instruction commit strobe, nonzero means one commit this cycle.
REQ-008 pc  in  XLEN  committed PC.
REQ-009 instr  in  32  committed instruction word.
REQ-010 skip  in  1  commit result is not checked.
REQ-011 wen  in  1  commit writes a GPR.
REQ-012 wdest  in  8  destination register; only bits [4:0] are used.
REQ-013 wdata  in  XLEN  written value.
REQ-014 gpr_flat  in  NREG*XLEN  architectural register state; gpr_i occupies bits [i*XLEN +: XLEN].
REQ-015 trap_valid  in  1  trap event strobe.
REQ-016 trap_code  in  3  trap code; 0 means good trap.
REQ-017 cycle_cnt  in  64  cycle count reported by the core.
REQ-018 instr_cnt  in  64  instruction count reported by the core.
REQ-019 commit_count  out  64  commits accepted since reset.
REQ-020 last_pc  out  XLEN  PC of the most recent accepted commit.
REQ-021 last_instr  out  32  instruction of the most recent accepted commit.
REQ-022 mismatch  out  1  sticky flag: GPR state differs from the shadow register file.
REQ-023 mismatch_reg  out  5  lowest mismatching register index, captured at the first mismatch.
REQ-024 mismatch_pc  out  XLEN  PC of the commit that preceded the first mismatch.
REQ-025 trap_hit  out  1  sticky flag: a trap has been seen.
REQ-026 good_trap  out  1  trap_hit and the captured code is 0.
REQ-027 trap_pc  out  XLEN  last_pc captured at the trap.
REQ-028 cnt_error  out  1  at trap time, instr_cnt differed from commit_count.

Function
REQ-029 A commit is accepted when valid=1 and trap_hit=0; each accepted commit increments commit_count by 1 and updates last_pc and last_instr.
REQ-030 Shadow file: NREG x XLEN registers; entry 0 always reads 0.
REQ-031 An accepted commit with wen=1 and wdest[4:0]!=0 writes wdata into the shadow entry on the same edge, whether or not skip is set.
REQ-032 Compare stage: on the edge after an accepted commit with skip=0, the block compares all NREG gpr_flat words against the shadow file; no compare occurs otherwise.
REQ-033 On the first compare mismatch, mismatch is set to 1 and mismatch_reg and mismatch_pc are captured; later mismatches do not change the captured values.
REQ-034 A mismatch on entry 0 (gpr_0 != 0) is flagged as index 0.
REQ-035 When trap_valid=1 and trap_hit=0: trap_hit is set, trap_code and trap_pc are captured, and cnt_error is set to (instr_cnt != commit_count including any commit accepted in the same cycle).
REQ-036 When a commit and a trap arrive in the same cycle, the commit is accepted first.
REQ-037 commit_count wraps at 2^64.
REQ-038 cycle_cnt is informational only and drives no output.

Reset
REQ-039 While reset_n=0, all outputs, the shadow file, the captured fields and the compare pipeline register are 0, and the block takes effect asynchronously.
REQ-040 A commit in flight in the compare stage when reset asserts is discarded.

Structure
REQ-041 A shared package holds XLEN, NREG, the trap code constant GOOD_TRAP=0 and the register-index type.
REQ-042 The shadow register file is implemented as one sub-module, difftest_shadow_rf, with 1 write port and a flat read of all entries.

Verification
REQ-043 Scenario 1: valid, wen=1, wdest=5, wdata=0x1234, with gpr_5=0x1234 on the next cycle -> mismatch=0, commit_count=1.
REQ-044 Scenario 2: same commit, but gpr_5=0x1235 -> mismatch=1, mismatch_reg=5.
REQ-045 Scenario 3: commit with skip=1, wdest=3, gpr_3 differing -> mismatch=0, and the shadow entry for register 3 equals wdata.
REQ-046 Scenario 4: 10 commits, then trap_valid with trap_code=0 and instr_cnt=10 -> good_trap=1, cnt_error=0; a further commit leaves commit_count=10.
REQ-047 Scenario 5: trap with trap_code=1 and instr_cnt=9 after 10 commits -> good_trap=0, cnt_error=1.
REQ-048 Scenario 6: reset_n asserted mid-sequence -> all outputs read 0 immediately.

Source files
------------

// File: rtl/difftest_instr_commit_pkg.sv
// Shared definitions for the instruction-commit difftest checker: default
// datapath geometry, the good-trap code and the GPR index type.
package difftest_instr_commit_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    // Trap code reported by the core for a successful program exit.
    localparam logic [2:0] GOOD_TRAP = 3'd0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Only the low bits of the core's 8-bit destination field name a GPR.
    function automatic reg_idx_t dest_idx(input logic [7:0] wdest);
        return wdest[REG_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/difftest_instr_commit_shadow_rf.sv
// Shadow architectural register file for the difftest checker.
// One write port, every entry visible at once on a flat read bus.
// Entry 0 is hard-wired to zero and never stored.
module difftest_shadow_rf
    import difftest_instr_commit_pkg::*;
#(
    parameter int XLEN = difftest_instr_commit_pkg::XLEN,
    parameter int NREG = difftest_instr_commit_pkg::NREG
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 we,
    input  reg_idx_t             waddr,
    input  logic [XLEN-1:0]      wdata,
    output logic [NREG*XLEN-1:0] rdata_flat
);

    assign rdata_flat[0 +: XLEN] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        logic [XLEN-1:0] q;

        // Capture the write data when this entry is addressed.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else if (we && (int'(waddr) == i)) begin
                q <= wdata;
            end
        end

        assign rdata_flat[i*XLEN +: XLEN] = q;
    end

endmodule

// File: rtl/difftest_instr_commit.sv
// Instruction-commit difftest checker.
// Tracks accepted commits, mirrors GPR writes into a shadow register file,
// compares the core's reported GPR state against the shadow one cycle after
// each checked commit, and records the first trap seen.
module difftest_instr_commit
    import difftest_instr_commit_pkg::*;
#(
    parameter int XLEN = difftest_instr_commit_pkg::XLEN,
    parameter int NREG = difftest_instr_commit_pkg::NREG
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           coreid,
    input  logic [7:0]           index,
    input  logic                 valid,
    input  logic [XLEN-1:0]      pc,
    input  logic [31:0]          instr,
    input  logic                 skip,
    input  logic                 wen,
    input  logic [7:0]           wdest,
    input  logic [XLEN-1:0]      wdata,
    input  logic [NREG*XLEN-1:0] gpr_flat,
    input  logic                 trap_valid,
    input  logic [2:0]           trap_code,
    input  logic [63:0]          cycle_cnt,
    input  logic [63:0]          instr_cnt,
    output logic [63:0]          commit_count,
    output logic [XLEN-1:0]      last_pc,
    output logic [31:0]          last_instr,
    output logic                 mismatch,
    output reg_idx_t             mismatch_reg,
    output logic [XLEN-1:0]      mismatch_pc,
    output logic                 trap_hit,
    output logic                 good_trap,
    output logic [XLEN-1:0]      trap_pc,
    output logic                 cnt_error
);

    logic                 commit_acc;
    logic                 trap_fire;
    logic [63:0]          count_nxt;
    logic [XLEN-1:0]      last_pc_nxt;
    reg_idx_t             wr_idx;
    logic                 shadow_we;
    logic [NREG*XLEN-1:0] shadow_flat;

    logic                 cmp_vld_p1;
    logic [XLEN-1:0]      cmp_pc_p1;
    logic                 diff_any;
    reg_idx_t             diff_idx;

    logic [7:0]           coreid_q;
    logic [7:0]           index_q;
    logic [2:0]           trap_code_q;

    // Once a trap has been recorded the checker stops accepting commits.
    assign commit_acc  = valid && !trap_hit;
    assign trap_fire   = trap_valid && !trap_hit;

    // A commit in the trap cycle counts first, so the trap sees the
    // post-commit count and PC.
    assign count_nxt   = commit_acc ? commit_count + 64'd1 : commit_count;
    assign last_pc_nxt = commit_acc ? pc : last_pc;

    assign wr_idx      = dest_idx(wdest);
    assign shadow_we   = commit_acc && wen && (wr_idx != '0);

    difftest_shadow_rf #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_shadow (
        .clock      (clock),
        .reset_n    (reset_n),
        .we         (shadow_we),
        .waddr      (wr_idx),
        .wdata      (wdata),
        .rdata_flat (shadow_flat)
    );

    // Commit bookkeeping: count, last PC/instruction and status fields.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            commit_count <= '0;
            last_pc      <= '0;
            last_instr   <= '0;
            index_q      <= '0;
            coreid_q     <= '0;
        end else begin
            coreid_q <= coreid;
            if (commit_acc) begin
                commit_count <= count_nxt;
                last_pc      <= pc;
                last_instr   <= instr;
                index_q      <= index;
            end
        end
    end

    // ---- stage p0 -> p1: remember a checked commit for next-cycle compare
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmp_vld_p1 <= 1'b0;
            cmp_pc_p1  <= '0;
        end else begin
            cmp_vld_p1 <= commit_acc && !skip;
            cmp_pc_p1  <= pc;
        end
    end

    // Lowest-index disagreement between the core's GPRs and the shadow file.
    always_comb begin
        diff_any = 1'b0;
        diff_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (gpr_flat[i*XLEN +: XLEN] != shadow_flat[i*XLEN +: XLEN]) begin
                diff_any = 1'b1;
                diff_idx = REG_IDX_W'(i);
            end
        end
    end

    // ---- stage p1: sticky mismatch capture; only the first one is kept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mismatch     <= 1'b0;
            mismatch_reg <= '0;
            mismatch_pc  <= '0;
        end else if (cmp_vld_p1 && diff_any && !mismatch) begin
            mismatch     <= 1'b1;
            mismatch_reg <= diff_idx;
            mismatch_pc  <= cmp_pc_p1;
        end
    end

    // First trap capture: code, PC and commit-count consistency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trap_hit    <= 1'b0;
            trap_code_q <= '0;
            trap_pc     <= '0;
            cnt_error   <= 1'b0;
        end else if (trap_fire) begin
            trap_hit    <= 1'b1;
            trap_code_q <= trap_code;
            trap_pc     <= last_pc_nxt;
            cnt_error   <= (instr_cnt != count_nxt);
        end
    end

    assign good_trap = trap_hit && (trap_code_q == GOOD_TRAP);

    // Informational inputs and status latches with no output of their own.
    logic unused_status;
    assign unused_status = ^{cycle_cnt, coreid_q, index_q, wdest[7:REG_IDX_W]};

endmodule

// File: tb/tb_difftest_instr_commit.sv
// Self-checking bench for difftest_instr_commit: a vector table for the
// single-commit compare cases, hand-written trap/reset sequences, and a
// randomized run checked every cycle against a behavioural model.
module tb_difftest_instr_commit;

    localparam int XL = 32;
    localparam int NR = 32;

    logic              clock;
    logic              reset_n;
    logic [7:0]        coreid;
    logic [7:0]        index;
    logic              valid;
    logic [XL-1:0]     pc;
    logic [31:0]       instr;
    logic              skip;
    logic              wen;
    logic [7:0]        wdest;
    logic [XL-1:0]     wdata;
    logic [NR*XL-1:0]  gpr_flat;
    logic              trap_valid;
    logic [2:0]        trap_code;
    logic [63:0]       cycle_cnt;
    logic [63:0]       instr_cnt;
    logic [63:0]       commit_count;
    logic [XL-1:0]     last_pc;
    logic [31:0]       last_instr;
    logic              mismatch;
    logic [4:0]        mismatch_reg;
    logic [XL-1:0]     mismatch_pc;
    logic              trap_hit;
    logic              good_trap;
    logic [XL-1:0]     trap_pc;
    logic              cnt_error;

    logic [XL-1:0]     gpr_w [NR];

    int n_chk = 0;
    int n_fail = 0;

    difftest_instr_commit #(.XLEN(XL), .NREG(NR)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .coreid       (coreid),
        .index        (index),
        .valid        (valid),
        .pc           (pc),
        .instr        (instr),
        .skip         (skip),
        .wen          (wen),
        .wdest        (wdest),
        .wdata        (wdata),
        .gpr_flat     (gpr_flat),
        .trap_valid   (trap_valid),
        .trap_code    (trap_code),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt),
        .commit_count (commit_count),
        .last_pc      (last_pc),
        .last_instr   (last_instr),
        .mismatch     (mismatch),
        .mismatch_reg (mismatch_reg),
        .mismatch_pc  (mismatch_pc),
        .trap_hit     (trap_hit),
        .good_trap    (good_trap),
        .trap_pc      (trap_pc),
        .cnt_error    (cnt_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        gpr_flat = '0;
        for (int i = 0; i < NR; i++) gpr_flat[i*XL +: XL] = gpr_w[i];
    end

    // ---------------- behavioural reference model ----------------
    longint unsigned m_cnt;
    logic [XL-1:0]   m_lpc, m_linstr, m_ppc, m_mpc, m_tpc;
    logic [XL-1:0]   m_sh [NR];
    bit              m_pend, m_mis, m_trap, m_cerr;
    logic [4:0]      m_mreg;
    logic [2:0]      m_tcode;

    task automatic m_reset();
        m_cnt = 0; m_lpc = '0; m_linstr = '0; m_ppc = '0; m_mpc = '0; m_tpc = '0;
        m_pend = 0; m_mis = 0; m_trap = 0; m_cerr = 0; m_mreg = '0; m_tcode = '0;
        for (int i = 0; i < NR; i++) m_sh[i] = '0;
    endtask

    // One clock edge of the checker, evaluated with the inputs present before it.
    task automatic m_edge();
        bit trap_before;
        bit acc;
        trap_before = m_trap;
        if (m_pend && !m_mis) begin
            for (int i = 0; i < NR; i++) begin
                if (!m_mis && gpr_w[i] != ((i == 0) ? '0 : m_sh[i])) begin
                    m_mis = 1; m_mreg = 5'(i); m_mpc = m_ppc;
                end
            end
        end
        acc = valid && !trap_before;
        if (acc) begin
            m_cnt = m_cnt + 1;
            m_lpc = pc;
            m_linstr = instr;
            if (wen && wdest[4:0] != 5'd0) m_sh[wdest[4:0]] = wdata;
        end
        m_pend = acc && !skip;
        m_ppc = pc;
        if (trap_valid && !trap_before) begin
            m_trap = 1; m_tcode = trap_code; m_tpc = m_lpc;
            m_cerr = (instr_cnt != 64'(m_cnt));
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".commit_count"}, commit_count, 64'(m_cnt));
        chk({tag, ".last_pc"}, 64'(last_pc), 64'(m_lpc));
        chk({tag, ".last_instr"}, 64'(last_instr), 64'(m_linstr));
        chk({tag, ".mismatch"}, 64'(mismatch), 64'(m_mis));
        chk({tag, ".mismatch_reg"}, 64'(mismatch_reg), 64'(m_mreg));
        chk({tag, ".mismatch_pc"}, 64'(mismatch_pc), 64'(m_mpc));
        chk({tag, ".trap_hit"}, 64'(trap_hit), 64'(m_trap));
        chk({tag, ".good_trap"}, 64'(good_trap), 64'(m_trap && m_tcode == 3'd0));
        chk({tag, ".trap_pc"}, 64'(trap_pc), 64'(m_tpc));
        chk({tag, ".cnt_error"}, 64'(cnt_error), 64'(m_cerr));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        m_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        valid = 0; skip = 0; wen = 0; wdest = '0; wdata = '0; pc = '0; instr = '0;
        trap_valid = 0; trap_code = '0; instr_cnt = '0; index = '0; coreid = '0;
        cycle_cnt = '0;
    endtask

    task automatic gpr_zero();
        for (int i = 0; i < NR; i++) gpr_w[i] = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        gpr_zero();
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;
        tick("post_reset");
    endtask

    task automatic commit(input logic [XL-1:0] a_pc, input bit a_wen, input logic [7:0] a_dest,
                          input logic [XL-1:0] a_data, input bit a_skip, input string tag);
        valid = 1; pc = a_pc; instr = a_pc ^ 32'h0000_0013; wen = a_wen; wdest = a_dest;
        wdata = a_data; skip = a_skip;
        tick(tag);
        valid = 0; wen = 0; skip = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  wdest;
        logic [31:0] wdata;
        bit          skip;
        logic [31:0] gval;
        logic [31:0] g0;
        bit          exp_mis;
        logic [4:0]  exp_reg;
    } vec_t;

    vec_t tbl [7];

    logic [XL-1:0] c_arch [NR];

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        gpr_zero();

        tbl[0] = '{8'd5,    32'h0000_1234, 0, 32'h0000_1234, 32'h0, 0, 5'd0};
        tbl[1] = '{8'd5,    32'h0000_1234, 0, 32'h0000_1235, 32'h0, 1, 5'd5};
        tbl[2] = '{8'd3,    32'h0000_abcd, 1, 32'h0000_0001, 32'h0, 0, 5'd0};
        tbl[3] = '{8'd0,    32'h0000_0055, 0, 32'h0000_0000, 32'h0, 0, 5'd0};
        tbl[4] = '{8'h25,   32'h0000_0077, 0, 32'h0000_0077, 32'h0, 0, 5'd0};
        tbl[5] = '{8'd31,   32'hffff_ffff, 0, 32'hffff_ffff, 32'h0, 0, 5'd0};
        tbl[6] = '{8'd7,    32'h0000_0009, 0, 32'h0000_0009, 32'h1, 1, 5'd0};

        for (int k = 0; k < 7; k++) begin
            logic [31:0] vpc;
            vpc = 32'h1000 + 32'(k) * 4;
            do_reset();
            commit(vpc, 1, tbl[k].wdest, tbl[k].wdata, tbl[k].skip, "tbl_commit");
            gpr_w[tbl[k].wdest[4:0]] = tbl[k].gval;
            gpr_w[0] = tbl[k].g0;
            tick("tbl_cmp");
            chk($sformatf("tbl%0d.mismatch", k), 64'(mismatch), 64'(tbl[k].exp_mis));
            chk($sformatf("tbl%0d.mismatch_reg", k), 64'(mismatch_reg), 64'(tbl[k].exp_reg));
            chk($sformatf("tbl%0d.mismatch_pc", k), 64'(mismatch_pc),
                tbl[k].exp_mis ? 64'(vpc) : 64'd0);
            chk($sformatf("tbl%0d.commit_count", k), commit_count, 64'd1);
        end

        // Skipped commit still writes the shadow: a later checked commit
        // with gpr_3 equal to the skipped write data must not mismatch.
        do_reset();
        commit(32'h200, 1, 8'd3, 32'h0000_abcd, 1, "skip_wr");
        gpr_w[3] = 32'h1;
        tick("skip_cmp");
        chk("skip.mismatch", 64'(mismatch), 64'd0);
        gpr_w[3] = 32'h0000_abcd;
        commit(32'h204, 0, 8'd0, 32'h0, 0, "skip_chk_commit");
        tick("skip_chk_cmp");
        chk("skip.shadow3", 64'(mismatch), 64'd0);

        // Ten commits then a good trap with a consistent count.
        do_reset();
        for (int k = 0; k < 10; k++) commit(32'h100 + 32'(k) * 4, 0, 8'd0, 32'h0, 0, "s4_commit");
        trap_valid = 1; trap_code = 3'd0; instr_cnt = 64'd10;
        tick("s4_trap");
        trap_valid = 0;
        chk("s4.good_trap", 64'(good_trap), 64'd1);
        chk("s4.cnt_error", 64'(cnt_error), 64'd0);
        chk("s4.trap_pc", 64'(trap_pc), 64'h124);
        commit(32'h999, 1, 8'd4, 32'h55, 0, "s4_late");
        chk("s4.count_frozen", commit_count, 64'd10);
        chk("s4.last_pc_frozen", 64'(last_pc), 64'h124);

        // Ten commits then a bad trap with an inconsistent count.
        do_reset();
        for (int k = 0; k < 10; k++) commit(32'h300 + 32'(k) * 4, 0, 8'd0, 32'h0, 0, "s5_commit");
        trap_valid = 1; trap_code = 3'd1; instr_cnt = 64'd9;
        tick("s5_trap");
        trap_valid = 0;
        chk("s5.good_trap", 64'(good_trap), 64'd0);
        chk("s5.trap_hit", 64'(trap_hit), 64'd1);
        chk("s5.cnt_error", 64'(cnt_error), 64'd1);

        // Commit and trap in the same cycle: the commit counts first.
        do_reset();
        for (int k = 0; k < 3; k++) commit(32'h400 + 32'(k) * 4, 0, 8'd0, 32'h0, 0, "same_pre");
        valid = 1; pc = 32'h500; instr = 32'h73; trap_valid = 1; trap_code = 3'd0; instr_cnt = 64'd4;
        tick("same_cycle");
        valid = 0; trap_valid = 0;
        chk("same.commit_count", commit_count, 64'd4);
        chk("same.cnt_error", 64'(cnt_error), 64'd0);
        chk("same.trap_pc", 64'(trap_pc), 64'h500);

        // Asynchronous reset mid-sequence with a compare in flight.
        do_reset();
        commit(32'h40, 1, 8'd5, 32'h1234, 0, "s6_commit");
        gpr_w[5] = 32'h0000_dead;
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all("s6_async");
        chk("s6.commit_count", commit_count, 64'd0);
        chk("s6.last_pc", 64'(last_pc), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick("s6_after");
        chk("s6.inflight_dropped", 64'(mismatch), 64'd0);

        // Randomized runs against the model.
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int i = 0; i < NR; i++) c_arch[i] = '0;
            for (int cyc = 0; cyc < 120; cyc++) begin
                for (int i = 0; i < NR; i++) gpr_w[i] = c_arch[i];
                if ($urandom_range(0, 15) == 0)
                    gpr_w[$urandom_range(0, NR-1)] ^= (32'h1 << $urandom_range(0, 31));
                valid = ($urandom_range(0, 2) != 0);
                wen = $urandom_range(0, 1) == 1;
                skip = ($urandom_range(0, 7) == 0);
                wdest = 8'($urandom_range(0, 255));
                wdata = $urandom;
                pc = $urandom;
                instr = $urandom;
                index = 8'($urandom_range(0, 255));
                coreid = 8'($urandom_range(0, 255));
                cycle_cnt = {$urandom, $urandom};
                trap_valid = (cyc > 60) && ($urandom_range(0, 39) == 0);
                trap_code = 3'($urandom_range(0, 7));
                instr_cnt = 64'(m_cnt) + ((valid && !m_trap) ? 64'd1 : 64'd0)
                            + 64'($urandom_range(0, 1));
                tick("rand");
                if (valid && wen && wdest[4:0] != 5'd0) c_arch[wdest[4:0]] = wdata;
            end
            idle_inputs();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
